// File: rtl/serial_add_nbit_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_nbit_pkg
// Shared definitions for the bit-serial adder:
//   - FSM state encodings (binary, 2 bits)
//   - cnt_width(): bit counter width, clog2 of the operand width (minimum 1)
// No ports; imported by serial_add_nbit.
// -----------------------------------------------------------------------------
package serial_add_nbit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width needed for a counter that runs 0 .. w-1.
    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) begin
            if ((1 << r) < w) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_add.sv
// -----------------------------------------------------------------------------
// full_add
// One-bit full adder built from two half adders with the two partial carries
// ORed together (same structure as the full_sub cell).
// Ports:
//   Sum   output  sum bit
//   Cout  output  carry out
//   X     input   operand bit
//   Y     input   operand bit
//   Cin   input   carry in
// -----------------------------------------------------------------------------
module full_add (
    output logic Sum,
    output logic Cout,
    input  logic X,
    input  logic Y,
    input  logic Cin
);

    logic s1;
    logic c1;
    logic c2;

    half_add u_ha0 (
        .S (s1),
        .C (c1),
        .X (X),
        .Y (Y)
    );

    half_add u_ha1 (
        .S (Sum),
        .C (c2),
        .X (s1),
        .Y (Cin)
    );

    // The two partial carries can never both be 1, so OR is exact.
    assign Cout = c1 | c2;

endmodule

// File: rtl/half_add.sv
// -----------------------------------------------------------------------------
// half_add
// One-bit half adder.
// Ports:
//   S  output  sum bit   (X ^ Y)
//   C  output  carry bit (X & Y)
//   X  input   operand bit
//   Y  input   operand bit
// -----------------------------------------------------------------------------
module half_add (
    output logic S,
    output logic C,
    input  logic X,
    input  logic Y
);

    assign S = X ^ Y;
    assign C = X & Y;

endmodule

// File: rtl/serial_add_nbit.sv
// -----------------------------------------------------------------------------
// serial_add_nbit
// Bit-serial WIDTH-bit adder: Sum = A + B + CI, one bit per clock, LSB first,
// using a single full_add cell and a carry flip-flop.
//
// Parameters:
//   WIDTH  operand / sum width (2..32)
//
// Ports:
//   clk    input   rising-edge clock
//   rst    input   asynchronous active-high reset
//   start  input   request, sampled in IDLE or DONE only
//   A      input   augend, captured on accepted start
//   B      input   addend, captured on accepted start
//   CI     input   carry-in, captured on accepted start
//   Sum    output  result, stable from done until next accepted start
//   CO     output  carry-out of the MSB, same validity as Sum
//   OVF    output  signed overflow (only with SERIAL_ADD_OVF_EN defined)
//   busy   output  high while computing
//   done   output  one-cycle pulse, result valid
//
// Build option:
//   SERIAL_ADD_OVF_EN  adds the OVF port and its register.
// -----------------------------------------------------------------------------
module serial_add_nbit
    import serial_add_nbit_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
`ifdef SERIAL_ADD_OVF_EN
    output logic             OVF,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             co_r;
    logic             busy_r;
    logic             done_r;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_r;
`endif

    logic fa_sum;
    logic fa_cout;

    full_add u_fa (
        .Sum  (fa_sum),
        .Cout (fa_cout),
        .X    (a_sh[0]),
        .Y    (b_sh[0]),
        .Cin  (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            co_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        carry  <= CI;
                        cnt    <= '0;
                        sum_r  <= '0;
                        co_r   <= 1'b0;
                        busy_r <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_r  <= 1'b0;
`endif
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // Each new sum bit enters at the MSB; after WIDTH shifts the
                    // first (LSB) bit has reached position 0.
                    sum_r <= {fa_sum, sum_r[WIDTH-1:1]};
                    carry <= fa_cout;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        co_r   <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB here.
                        ovf_r  <= carry ^ fa_cout;
`endif
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign Sum  = sum_r;
    assign CO   = co_r;
    assign busy = busy_r;
    assign done = done_r;
`ifdef SERIAL_ADD_OVF_EN
    assign OVF  = ovf_r;
`endif

endmodule
